// File: rtl/ixc_ptx_call_seq_if.sv
//------------------------------------------------------------------------------
// ixc_ptx_call_seq_if
//
// Bundle of the call-sequencer signals exchanged with the requesting sources
// and with the PTX transaction top. Clock and reset are not part of the bundle.
//
//   hasPTX    PTX target present (low: requests complete at once with error)
//   reqVec    level request per source, held until its own ack
//   ackVec    one-cycle, one-hot completion pulse
//   errVec    error flag per source, valid together with ackVec
//   callEv    one-cycle call pulse towards the PTX top
//   callEvOn  level, high from the callEv cycle until return/timeout sampled
//   callId    index of the granted source, stable while callEvOn
//   xptRtn    return pulse from the PTX top
//   dly       post-return gap length in cycles (0..3)
//   tmoLimit  return timeout in cycles, 0 disables the timeout
//   busy      sequencer not idle
//   strayRtn  sticky flag: a return arrived while no call was in flight
//
// modport slave  : the sequencer itself
// modport master : the environment (sources + PTX top)
//------------------------------------------------------------------------------
interface ixc_ptx_call_seq_if #(
   parameter int unsigned NUM_SRC = 4,
   parameter int unsigned ID_W    = 2,
   parameter int unsigned TMO_W   = 16
);
   logic               hasPTX;
   logic [NUM_SRC-1:0] reqVec;
   logic [NUM_SRC-1:0] ackVec;
   logic [NUM_SRC-1:0] errVec;
   logic               callEv;
   logic               callEvOn;
   logic [ID_W-1:0]    callId;
   logic               xptRtn;
   logic [1:0]         dly;
   logic [TMO_W-1:0]   tmoLimit;
   logic               busy;
   logic               strayRtn;

   modport slave (
      input  hasPTX, reqVec, xptRtn, dly, tmoLimit,
      output ackVec, errVec, callEv, callEvOn, callId, busy, strayRtn
   );

   modport master (
      output hasPTX, reqVec, xptRtn, dly, tmoLimit,
      input  ackVec, errVec, callEv, callEvOn, callId, busy, strayRtn
   );
endinterface

// File: rtl/ixc_ptx_call_seq.sv
//------------------------------------------------------------------------------
// ixc_ptx_call_seq
//
// Call sequencer in front of the PTX transaction top. Up to NUM_SRC sources
// raise level requests; a round-robin arbiter picks one, the sequencer issues
// a single outstanding call (callEv pulse, callEvOn level, callId), waits for
// xptRtn, optionally idles for a programmable gap, then acks the requester.
// A return timeout and a "no PTX present" path complete requests with error
// so a source can never hang.
//
// Ports:
//   uClk   clock
//   uRstN  asynchronous active-low reset
//   bus    ixc_ptx_call_seq_if.slave (request/ack vectors, call handshake,
//          configuration and status; see the interface file)
//
// All outputs come straight from flops. State flow:
//   IDLE -> CALL (1 cycle) -> WAIT -> [GAP for dly cycles] -> IDLE
//------------------------------------------------------------------------------
module ixc_ptx_call_seq #(
   parameter int unsigned NUM_SRC = 4,   // 2..16
   parameter int unsigned ID_W    = 2,   // 2**ID_W >= NUM_SRC
   parameter int unsigned TMO_W   = 16
) (
   input logic               uClk,
   input logic               uRstN,
   ixc_ptx_call_seq_if.slave bus
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALL = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_GAP  = 2'd3;

   logic [1:0]         state_q,    state_d;
   logic [ID_W-1:0]    ptr_q,      ptr_d;
   logic [ID_W-1:0]    callId_q,   callId_d;
   logic [TMO_W-1:0]   cnt_q,      cnt_d;
   logic [1:0]         gap_q,      gap_d;
   logic [NUM_SRC-1:0] ackVec_q,   ackVec_d;
   logic [NUM_SRC-1:0] errVec_q,   errVec_d;
   logic               callEv_q,   callEv_d;
   logic               callEvOn_q, callEvOn_d;
   logic               busy_q,     busy_d;
   logic               strayRtn_q, strayRtn_d;

   logic [NUM_SRC-1:0] eligible;
   logic [NUM_SRC-1:0] elig_sh;
   logic [NUM_SRC-1:0] winOh;
   logic [NUM_SRC-1:0] idOh;
   logic [ID_W-1:0]    winner;
   logic               found;
   logic               done;
   logic               doneErr;
   int unsigned        idx;

   //---------------------------------------------------------------------------
   // Round-robin arbiter. A source acked in this very cycle still has its
   // request up (it drops one cycle later), so it is masked here to keep it
   // from being granted a second time.
   //---------------------------------------------------------------------------
   always_comb begin
      eligible = bus.reqVec & ~ackVec_q;
      found    = 1'b0;
      winner   = '0;
      idx      = 0;
      elig_sh  = '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         // search order ptr, ptr+1, ... wrapping modulo NUM_SRC
         idx = 32'(ptr_q) + i;
         if (idx >= NUM_SRC) begin
            idx = idx - NUM_SRC;
         end
         elig_sh = eligible >> idx;
         if (!found && elig_sh[0]) begin
            found  = 1'b1;
            winner = ID_W'(idx);
         end
      end
      winOh = NUM_SRC'(1'b1) << winner;
      idOh  = NUM_SRC'(1'b1) << callId_q;
   end

   //---------------------------------------------------------------------------
   // Next-state logic. Registered outputs are derived from the next state so
   // that callEv/callEvOn/busy line up with the state they describe.
   //---------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      callId_d   = callId_q;
      cnt_d      = cnt_q;
      gap_d      = gap_q;
      ackVec_d   = '0;
      errVec_d   = '0;
      done       = 1'b0;
      doneErr    = 1'b0;
      strayRtn_d = strayRtn_q |
                   (bus.xptRtn & ((state_q == S_IDLE) || (state_q == S_GAP)));

      case (state_q)
         S_IDLE: begin
            if (found) begin
               ptr_d = (32'(winner) == NUM_SRC - 1) ? '0 : winner + 1'b1;
               if (bus.hasPTX) begin
                  callId_d = winner;
                  state_d  = S_CALL;
               end else begin
                  // no target: complete immediately with error, stay idle
                  ackVec_d = winOh;
                  errVec_d = winOh;
               end
            end
         end

         S_CALL: begin
            cnt_d = '0;
            if (bus.xptRtn) begin
               done = 1'b1;
            end else begin
               state_d = S_WAIT;
            end
         end

         S_WAIT: begin
            cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
            // a return in the timeout cycle wins and completes without error
            if (bus.xptRtn) begin
               done = 1'b1;
            end else if ((bus.tmoLimit != '0) && (cnt_q == bus.tmoLimit)) begin
               done    = 1'b1;
               doneErr = 1'b1;
            end
         end

         S_GAP: begin
            if (gap_q == 2'd0) begin
               state_d = S_IDLE;
            end else begin
               gap_d = gap_q - 2'd1;
            end
         end

         default: state_d = S_IDLE;
      endcase

      if (done) begin
         ackVec_d = idOh;
         errVec_d = {NUM_SRC{doneErr}} & idOh;
         // gap_q counts the remaining GAP cycles after the current one
         gap_d    = bus.dly - 2'd1;
         state_d  = (bus.dly != 2'd0) ? S_GAP : S_IDLE;
      end

      callEv_d   = (state_d == S_CALL);
      callEvOn_d = (state_d == S_CALL) || (state_d == S_WAIT);
      busy_d     = (state_d != S_IDLE);
   end

   //---------------------------------------------------------------------------
   // State and output registers
   //---------------------------------------------------------------------------
   always_ff @(posedge uClk or negedge uRstN) begin
      if (!uRstN) begin
         state_q    <= S_IDLE;
         ptr_q      <= '0;
         callId_q   <= '0;
         cnt_q      <= '0;
         gap_q      <= '0;
         ackVec_q   <= '0;
         errVec_q   <= '0;
         callEv_q   <= 1'b0;
         callEvOn_q <= 1'b0;
         busy_q     <= 1'b0;
         strayRtn_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         callId_q   <= callId_d;
         cnt_q      <= cnt_d;
         gap_q      <= gap_d;
         ackVec_q   <= ackVec_d;
         errVec_q   <= errVec_d;
         callEv_q   <= callEv_d;
         callEvOn_q <= callEvOn_d;
         busy_q     <= busy_d;
         strayRtn_q <= strayRtn_d;
      end
   end

   assign bus.ackVec   = ackVec_q;
   assign bus.errVec   = errVec_q;
   assign bus.callEv   = callEv_q;
   assign bus.callEvOn = callEvOn_q;
   assign bus.callId   = callId_q;
   assign bus.busy     = busy_q;
   assign bus.strayRtn = strayRtn_q;

endmodule

// File: tb/tb_ixc_ptx_call_seq.sv
//------------------------------------------------------------------------------
// tb_ixc_ptx_call_seq
//
// Directed bench for ixc_ptx_call_seq. Every call and ack the sequencer is
// expected to produce is pushed into a scoreboard queue (with the cycle it
// must appear in) when the stimulus is driven; a monitor run every cycle pops
// and compares. Sources drop their request the cycle after their own ack.
//------------------------------------------------------------------------------
module tb_ixc_ptx_call_seq;

   localparam int unsigned NUM_SRC = 4;
   localparam int unsigned ID_W    = 2;
   localparam int unsigned TMO_W   = 16;

   typedef struct {
      bit         is_ack;
      logic [1:0] id;
      logic [3:0] ack;
      logic [3:0] err;
      int         cyc;
   } exp_t;

   logic       uClk;
   logic       uRstN;
   logic [3:0] prevAck;
   int         cyc;
   int         checks;
   int         failures;
   int         on_cnt;
   int         ev_cnt;
   int         b_cnt;
   exp_t       sb[$];

   ixc_ptx_call_seq_if #(.NUM_SRC(NUM_SRC), .ID_W(ID_W), .TMO_W(TMO_W)) bus ();

   ixc_ptx_call_seq #(.NUM_SRC(NUM_SRC), .ID_W(ID_W), .TMO_W(TMO_W)) dut (
      .uClk  (uClk),
      .uRstN (uRstN),
      .bus   (bus)
   );

   initial uClk = 1'b0;
   always #5 uClk = ~uClk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input bit is_ack, input logic [1:0] id, input logic [3:0] ack,
                       input logic [3:0] err, input int at);
      exp_t e;
      e.is_ack = is_ack;
      e.id     = id;
      e.ack    = ack;
      e.err    = err;
      e.cyc    = at;
      sb.push_back(e);
   endtask

   task automatic monitor();
      exp_t e;
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
         e = sb.pop_front();
         chk("sb_missed_event_cyc", 32'(cyc), 32'(e.cyc));
      end
      if (bus.callEv === 1'b1) begin
         if (sb.size() == 0) begin
            chk("sb_unexpected_call", 32'(sb.size()), 32'd1);
         end else begin
            e = sb.pop_front();
            chk("call_kind_is_ack", 32'd0, 32'(e.is_ack));
            chk("call_id", 32'(bus.callId), 32'(e.id));
            chk("call_cyc", 32'(cyc), 32'(e.cyc));
         end
      end
      if (bus.ackVec !== 4'b0000) begin
         if (sb.size() == 0) begin
            chk("sb_unexpected_ack", 32'(sb.size()), 32'd1);
         end else begin
            e = sb.pop_front();
            chk("ack_kind_is_ack", 32'd1, 32'(e.is_ack));
            chk("ack_vec", 32'(bus.ackVec), 32'(e.ack));
            chk("err_vec", 32'(bus.errVec), 32'(e.err));
            chk("ack_cyc", 32'(cyc), 32'(e.cyc));
         end
      end
   endtask

   // advance one cycle; sample 1 ns after the rising edge
   task automatic tick();
      @(posedge uClk);
      #1;
      cyc++;
      bus.reqVec = bus.reqVec & ~prevAck;
      prevAck    = bus.ackVec;
      monitor();
   endtask

   task automatic do_reset();
      uRstN = 1'b0;
      tick();
      tick();
      uRstN = 1'b1;
   endtask

   initial begin
      checks       = 0;
      failures     = 0;
      cyc          = 0;
      prevAck      = '0;
      uRstN        = 1'b0;
      bus.hasPTX   = 1'b1;
      bus.reqVec   = '0;
      bus.xptRtn   = 1'b0;
      bus.dly      = 2'd0;
      bus.tmoLimit = '0;

      // reset state
      tick();
      tick();
      chk("rst_ackVec",   32'(bus.ackVec),   32'd0);
      chk("rst_errVec",   32'(bus.errVec),   32'd0);
      chk("rst_callEv",   32'(bus.callEv),   32'd0);
      chk("rst_callEvOn", 32'(bus.callEvOn), 32'd0);
      chk("rst_callId",   32'(bus.callId),   32'd0);
      chk("rst_busy",     32'(bus.busy),     32'd0);
      chk("rst_strayRtn", 32'(bus.strayRtn), 32'd0);
      uRstN = 1'b1;

      // single source 0, return 3 cycles after callEv
      bus.reqVec = 4'b0001;
      push(1'b0, 2'd0, 4'b0000, 4'b0000, cyc + 1);
      on_cnt = 0;
      ev_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         on_cnt += int'(bus.callEvOn);
         ev_cnt += int'(bus.callEv);
      end
      push(1'b1, 2'd0, 4'b0001, 4'b0000, cyc + 1);
      bus.xptRtn = 1'b1;
      tick();
      bus.xptRtn = 1'b0;
      on_cnt += int'(bus.callEvOn);
      ev_cnt += int'(bus.callEv);
      for (int i = 0; i < 3; i++) begin
         tick();
         ev_cnt += int'(bus.callEv);
      end
      chk("t1_callEvOn_cycles", 32'(on_cnt), 32'd4);
      chk("t1_callEv_cycles",   32'(ev_cnt), 32'd1);

      // all four requesting, immediate return, dly=0: 0,1,2,3,0 every 3 cycles
      do_reset();
      bus.reqVec = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         push(1'b0, 2'(k % 4), 4'b0000, 4'b0000, cyc + 1);
         tick();
         bus.reqVec = (k < 4) ? 4'b1111 : 4'b0001;
         tick();
         push(1'b1, 2'(k % 4), 4'(1 << (k % 4)), 4'b0000, cyc + 1);
         bus.xptRtn = 1'b1;
         tick();
         bus.xptRtn = 1'b0;
      end
      tick();
      tick();

      // dly=3 gap between ack of 0 and the grant of 1
      do_reset();
      bus.reqVec = 4'b0011;
      bus.dly    = 2'd3;
      push(1'b0, 2'd0, 4'b0000, 4'b0000, cyc + 1);
      tick();
      tick();
      push(1'b1, 2'd0, 4'b0001, 4'b0000, cyc + 1);
      push(1'b0, 2'd1, 4'b0000, 4'b0000, cyc + 5);
      bus.xptRtn = 1'b1;
      tick();
      bus.xptRtn = 1'b0;
      bus.dly    = 2'd0;
      b_cnt = int'(bus.busy);
      for (int i = 0; i < 3; i++) begin
         tick();
         b_cnt += int'(bus.busy);
      end
      chk("t3_gap_busy_cycles", 32'(b_cnt), 32'd3);
      chk("t3_idle_before_call", 32'(bus.busy), 32'd0);
      tick();
      tick();
      push(1'b1, 2'd1, 4'b0010, 4'b0000, cyc + 1);
      bus.xptRtn = 1'b1;
      tick();
      bus.xptRtn = 1'b0;
      tick();
      tick();

      // timeout with tmoLimit=5: err ack at callEv+7, then a stray return
      bus.tmoLimit = 16'd5;
      bus.reqVec   = 4'b0100;
      push(1'b0, 2'd2, 4'b0000, 4'b0000, cyc + 1);
      push(1'b1, 2'd2, 4'b0100, 4'b0100, cyc + 8);
      for (int i = 0; i < 7; i++) tick();
      chk("t4_callEvOn_last_wait", 32'(bus.callEvOn), 32'd1);
      tick();
      chk("t4_callEvOn_at_ack", 32'(bus.callEvOn), 32'd0);
      chk("t4_strayRtn_before", 32'(bus.strayRtn), 32'd0);
      tick();
      bus.xptRtn = 1'b1;
      tick();
      bus.xptRtn = 1'b0;
      chk("t4_strayRtn_set", 32'(bus.strayRtn), 32'd1);
      tick();

      // return coincident with the timeout cycle: ok completion
      bus.reqVec = 4'b1000;
      push(1'b0, 2'd3, 4'b0000, 4'b0000, cyc + 1);
      for (int i = 0; i < 7; i++) tick();
      push(1'b1, 2'd3, 4'b1000, 4'b0000, cyc + 1);
      bus.xptRtn = 1'b1;
      tick();
      bus.xptRtn   = 1'b0;
      bus.tmoLimit = '0;
      chk("t5_strayRtn_sticky", 32'(bus.strayRtn), 32'd1);
      tick();

      // no PTX: err acks to 0 then 2 on consecutive cycles, no call
      bus.hasPTX = 1'b0;
      bus.reqVec = 4'b0101;
      push(1'b1, 2'd0, 4'b0001, 4'b0001, cyc + 1);
      push(1'b1, 2'd2, 4'b0100, 4'b0100, cyc + 2);
      ev_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         ev_cnt += int'(bus.callEv) + int'(bus.busy);
      end
      chk("t6_no_call_no_busy", 32'(ev_cnt), 32'd0);
      bus.hasPTX = 1'b1;

      // reset during WAIT abandons the call; re-grant restarts from source 0
      bus.reqVec = 4'b1001;
      push(1'b0, 2'd3, 4'b0000, 4'b0000, cyc + 1);
      tick();
      tick();
      tick();
      #2;
      uRstN = 1'b0;
      #1;
      chk("t7_rst_callEvOn", 32'(bus.callEvOn), 32'd0);
      chk("t7_rst_busy",     32'(bus.busy),     32'd0);
      chk("t7_rst_callId",   32'(bus.callId),   32'd0);
      chk("t7_rst_callEv",   32'(bus.callEv),   32'd0);
      chk("t7_rst_ackVec",   32'(bus.ackVec),   32'd0);
      chk("t7_rst_strayRtn", 32'(bus.strayRtn), 32'd0);
      tick();
      uRstN = 1'b1;
      push(1'b0, 2'd0, 4'b0000, 4'b0000, cyc + 1);
      tick();
      tick();
      push(1'b1, 2'd0, 4'b0001, 4'b0000, cyc + 1);
      bus.xptRtn = 1'b1;
      tick();
      bus.xptRtn = 1'b0;
      push(1'b0, 2'd3, 4'b0000, 4'b0000, cyc + 1);
      tick();
      tick();
      push(1'b1, 2'd3, 4'b1000, 4'b0000, cyc + 1);
      bus.xptRtn = 1'b1;
      tick();
      bus.xptRtn = 1'b0;
      tick();
      tick();
      tick();

      chk("sb_all_events_seen", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
